// File: rtl/zone_climate_ctrl_if.sv
// Report record channel (valid/ready) from zone_climate_ctrl to the UART/LCD
// consumer. The controller is the master; the consumer is the slave.
interface zone_climate_ctrl_if #(
    parameter int NUM_ZONES = 4,
    parameter int DATA_W    = 8
);
    localparam int ZW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;

    logic              rpt_valid;
    logic              rpt_ready;
    logic [ZW-1:0]     rpt_zone;
    logic [DATA_W-1:0] rpt_temp;
    logic [DATA_W-1:0] rpt_hum;
    logic              rpt_fault;

    modport master (
        output rpt_valid, rpt_zone, rpt_temp, rpt_hum, rpt_fault,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid, rpt_zone, rpt_temp, rpt_hum, rpt_fault,
        output rpt_ready
    );
endinterface

// File: rtl/zone_climate_ctrl.sv
// Round-robin multi-zone climate poller: per-zone thresholds, hysteresis fan and
// humidifier control, sensor timeout faults, report stream. Option: CLIMATE_DWELL_EN.
module zone_climate_ctrl #(
    parameter int NUM_ZONES      = 4,
    parameter int DATA_W         = 8,
    parameter int POLL_CYCLES    = 2000000,
    parameter int TIMEOUT_CYCLES = 5000000,
    parameter int DEF_MAX_TEMP   = 8,
    parameter int DEF_MIN_TEMP   = 2,
    parameter int DEF_MAX_HUM    = 95,
    parameter int DEF_MIN_HUM    = 85,
`ifdef CLIMATE_DWELL_EN
    parameter int DWELL_CYCLES   = 100000000,
`endif
    localparam int ZW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic [NUM_ZONES-1:0]        o_dht_en,
    input  logic [NUM_ZONES-1:0]        i_dht_data_ready,
    input  logic [NUM_ZONES*DATA_W-1:0] i_temp_in,
    input  logic [NUM_ZONES*DATA_W-1:0] i_hum_in,
    input  logic                        i_cfg_wr,
    input  logic [ZW-1:0]               i_cfg_zone,
    input  logic [1:0]                  i_cfg_sel,
    input  logic [DATA_W-1:0]           i_cfg_val,
    output logic                        o_cfg_err,
    output logic [NUM_ZONES-1:0]        o_fan_on,
    output logic [NUM_ZONES-1:0]        o_hum_on,
    output logic [NUM_ZONES-1:0]        o_sensor_fault,
    zone_climate_ctrl_if.master         rpt
);
    localparam int PW = $clog2(POLL_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EVAL, S_REPORT} state_t;

    state_t                r_state;
    logic [ZW-1:0]         r_zone;
    logic [PW-1:0]         r_poll_cnt;
    logic [TW-1:0]         r_tmo_cnt;
    logic [DATA_W-1:0]     r_temp;
    logic [DATA_W-1:0]     r_hum;
    logic                  r_fault;
    logic [NUM_ZONES-1:0]  r_dht_en;
    logic [NUM_ZONES-1:0]  r_fan_on;
    logic [NUM_ZONES-1:0]  r_hum_on;
    logic [NUM_ZONES-1:0]  r_sensor_fault;
    logic                  r_rpt_valid;
    logic [ZW-1:0]         r_rpt_zone;
    logic [DATA_W-1:0]     r_rpt_temp;
    logic [DATA_W-1:0]     r_rpt_hum;
    logic                  r_rpt_fault;
    logic [DATA_W-1:0]     r_max_t [NUM_ZONES];
    logic [DATA_W-1:0]     r_min_t [NUM_ZONES];
    logic [DATA_W-1:0]     r_max_h [NUM_ZONES];
    logic [DATA_W-1:0]     r_min_h [NUM_ZONES];
    logic                  r_cfg_err;
    logic                  w_cfg_reject;
    logic                  w_fan_next;
    logic                  w_hum_next;

`ifdef CLIMATE_DWELL_EN
    localparam int DWW = $clog2(DWELL_CYCLES + 1);
    logic [DWW-1:0] r_fan_dwell [NUM_ZONES];
    logic [DWW-1:0] r_hum_dwell [NUM_ZONES];
    logic           w_fan_free;
    logic           w_hum_free;
    assign w_fan_free = (r_fan_dwell[r_zone] == DWW'(DWELL_CYCLES));
    assign w_hum_free = (r_hum_dwell[r_zone] == DWW'(DWELL_CYCLES));
`endif

    // A write is judged against the partner threshold of the same pair.
    always_comb begin
        w_cfg_reject = 1'b0;
        if (int'(i_cfg_zone) >= NUM_ZONES) begin
            w_cfg_reject = 1'b1;
        end else begin
            case (i_cfg_sel)
                2'd0:    w_cfg_reject = (r_min_t[i_cfg_zone] >= i_cfg_val);
                2'd1:    w_cfg_reject = (i_cfg_val >= r_max_t[i_cfg_zone]);
                2'd2:    w_cfg_reject = (r_min_h[i_cfg_zone] >= i_cfg_val);
                default: w_cfg_reject = (i_cfg_val >= r_max_h[i_cfg_zone]);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int z = 0; z < NUM_ZONES; z++) begin
                r_max_t[z] <= DATA_W'(DEF_MAX_TEMP);
                r_min_t[z] <= DATA_W'(DEF_MIN_TEMP);
                r_max_h[z] <= DATA_W'(DEF_MAX_HUM);
                r_min_h[z] <= DATA_W'(DEF_MIN_HUM);
            end
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= i_cfg_wr && w_cfg_reject;
            if (i_cfg_wr && !w_cfg_reject) begin
                case (i_cfg_sel)
                    2'd0:    r_max_t[i_cfg_zone] <= i_cfg_val;
                    2'd1:    r_min_t[i_cfg_zone] <= i_cfg_val;
                    2'd2:    r_max_h[i_cfg_zone] <= i_cfg_val;
                    default: r_min_h[i_cfg_zone] <= i_cfg_val;
                endcase
            end
        end
    end

    // Strict unsigned hysteresis; inside the band the actuator holds.
    always_comb begin
        w_fan_next = r_fan_on[r_zone];
        if (r_temp > r_max_t[r_zone])      w_fan_next = 1'b1;
        else if (r_temp < r_min_t[r_zone]) w_fan_next = 1'b0;
        w_hum_next = r_hum_on[r_zone];
        if (r_hum < r_min_h[r_zone])       w_hum_next = 1'b1;
        else if (r_hum > r_max_h[r_zone])  w_hum_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_zone         <= '0;
            r_poll_cnt     <= '0;
            r_tmo_cnt      <= '0;
            r_temp         <= '0;
            r_hum          <= '0;
            r_fault        <= 1'b0;
            r_dht_en       <= '0;
            r_fan_on       <= '0;
            r_hum_on       <= '0;
            r_sensor_fault <= '0;
            r_rpt_valid    <= 1'b0;
            r_rpt_zone     <= '0;
            r_rpt_temp     <= '0;
            r_rpt_hum      <= '0;
            r_rpt_fault    <= 1'b0;
`ifdef CLIMATE_DWELL_EN
            for (int z = 0; z < NUM_ZONES; z++) begin
                r_fan_dwell[z] <= DWW'(DWELL_CYCLES);
                r_hum_dwell[z] <= DWW'(DWELL_CYCLES);
            end
`endif
        end else begin
`ifdef CLIMATE_DWELL_EN
            for (int z = 0; z < NUM_ZONES; z++) begin
                if (r_fan_dwell[z] != DWW'(DWELL_CYCLES)) r_fan_dwell[z] <= r_fan_dwell[z] + 1'b1;
                if (r_hum_dwell[z] != DWW'(DWELL_CYCLES)) r_hum_dwell[z] <= r_hum_dwell[z] + 1'b1;
            end
`endif
            case (r_state)
                S_IDLE: begin
                    if (r_poll_cnt == PW'(POLL_CYCLES - 1)) begin
                        r_poll_cnt <= '0;
                        r_dht_en   <= NUM_ZONES'(1) << r_zone;
                        r_state    <= S_REQ;
                    end else begin
                        r_poll_cnt <= r_poll_cnt + 1'b1;
                    end
                end
                S_REQ: begin
                    r_dht_en  <= '0;
                    r_tmo_cnt <= '0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_dht_data_ready[r_zone]) begin
                        r_temp  <= i_temp_in[r_zone*DATA_W +: DATA_W];
                        r_hum   <= i_hum_in[r_zone*DATA_W +: DATA_W];
                        r_fault <= 1'b0;
                        r_state <= S_EVAL;
                    end else if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_temp  <= '0;
                        r_hum   <= '0;
                        r_fault <= 1'b1;
                        r_state <= S_EVAL;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                S_EVAL: begin
                    r_sensor_fault[r_zone] <= r_fault;
                    if (r_fault) begin
                        // Fail-safe: cool and stop humidifying on a dead sensor.
                        r_fan_on[r_zone] <= 1'b1;
                        r_hum_on[r_zone] <= 1'b0;
`ifdef CLIMATE_DWELL_EN
                        if (!r_fan_on[r_zone]) r_fan_dwell[r_zone] <= '0;
                        if (r_hum_on[r_zone])  r_hum_dwell[r_zone] <= '0;
`endif
                    end else begin
`ifdef CLIMATE_DWELL_EN
                        if ((w_fan_next != r_fan_on[r_zone]) && w_fan_free) begin
                            r_fan_on[r_zone]    <= w_fan_next;
                            r_fan_dwell[r_zone] <= '0;
                        end
                        if ((w_hum_next != r_hum_on[r_zone]) && w_hum_free) begin
                            r_hum_on[r_zone]    <= w_hum_next;
                            r_hum_dwell[r_zone] <= '0;
                        end
`else
                        r_fan_on[r_zone] <= w_fan_next;
                        r_hum_on[r_zone] <= w_hum_next;
`endif
                    end
                    r_state <= S_REPORT;
                end
                S_REPORT: begin
                    if (!r_rpt_valid) begin
                        r_rpt_valid <= 1'b1;
                        r_rpt_zone  <= r_zone;
                        r_rpt_temp  <= r_temp;
                        r_rpt_hum   <= r_hum;
                        r_rpt_fault <= r_fault;
                    end else if (rpt.rpt_ready) begin
                        r_rpt_valid <= 1'b0;
                        r_zone      <= (r_zone == ZW'(NUM_ZONES - 1)) ? '0 : r_zone + 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_dht_en       = r_dht_en;
    assign o_cfg_err      = r_cfg_err;
    assign o_fan_on       = r_fan_on;
    assign o_hum_on       = r_hum_on;
    assign o_sensor_fault = r_sensor_fault;
    assign rpt.rpt_valid  = r_rpt_valid;
    assign rpt.rpt_zone   = r_rpt_zone;
    assign rpt.rpt_temp   = r_rpt_temp;
    assign rpt.rpt_hum    = r_rpt_hum;
    assign rpt.rpt_fault  = r_rpt_fault;
endmodule

// File: tb/tb_zone_climate_ctrl.sv
// Directed table-driven bench for zone_climate_ctrl with two zones, short poll
// and timeout intervals, plus config, backpressure and mid-poll reset sequences.
`timescale 1ns/1ps
module tb_zone_climate_ctrl;
    localparam int NZ      = 2;
    localparam int DW      = 8;
    localparam int ZW      = 1;
    localparam int POLL    = 16;
    localparam int TIMEOUT = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NZ-1:0]   dht_en;
    logic [NZ-1:0]   dht_ready;
    logic [NZ*DW-1:0] temp_in;
    logic [NZ*DW-1:0] hum_in;
    logic            cfg_wr;
    logic [ZW-1:0]   cfg_zone;
    logic [1:0]      cfg_sel;
    logic [DW-1:0]   cfg_val;
    logic            cfg_err;
    logic [NZ-1:0]   fan_on;
    logic [NZ-1:0]   hum_on;
    logic [NZ-1:0]   sensor_fault;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    zone_climate_ctrl_if #(.NUM_ZONES(NZ), .DATA_W(DW)) rpt_if ();

    zone_climate_ctrl #(
        .NUM_ZONES(NZ), .DATA_W(DW), .POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .o_dht_en(dht_en), .i_dht_data_ready(dht_ready),
        .i_temp_in(temp_in), .i_hum_in(hum_in),
        .i_cfg_wr(cfg_wr), .i_cfg_zone(cfg_zone), .i_cfg_sel(cfg_sel),
        .i_cfg_val(cfg_val), .o_cfg_err(cfg_err),
        .o_fan_on(fan_on), .o_hum_on(hum_on), .o_sensor_fault(sensor_fault),
        .rpt(rpt_if)
    );

    typedef struct {
        int         zone;
        int         delay;
        logic       timeout;
        logic       decoy;
        logic       stall;
        int         temp;
        int         hum;
        logic [1:0] fan;
        logic [1:0] hm;
        logic [1:0] flt;
    } rec_t;

    rec_t tbl [16];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk(nm, {dht_en, fan_on, hum_on, sensor_fault, cfg_err, rpt_if.rpt_valid,
                 rpt_if.rpt_zone, rpt_if.rpt_temp, rpt_if.rpt_hum, rpt_if.rpt_fault}, 0);
    endtask

    task automatic wait_dht(input logic [NZ-1:0] exp, input string nm);
        int k = 0;
        while (dht_en == '0 && k < 200) begin
            tick();
            k++;
        end
        chk(nm, dht_en, exp);
    endtask

    task automatic set_zone(input int z, input int t, input int h);
        temp_in[z*DW +: DW] = DW'(t);
        hum_in[z*DW +: DW]  = DW'(h);
    endtask

    task automatic run_rec(input int i);
        rec_t          r;
        int            n;
        int            bad;
        logic [NZ-1:0] oh;
        r  = tbl[i];
        oh = NZ'(1) << r.zone;
        if (r.stall) rpt_if.rpt_ready = 1'b0;
        wait_dht(oh, $sformatf("rec%0d dht_en", i));
        tick();
        n = 1;
        chk($sformatf("rec%0d dht_en pulse", i), dht_en, 0);
        if (r.timeout) begin
            while (!rpt_if.rpt_valid && n < 200) begin
                tick();
                n++;
            end
            // Fault decided after TIMEOUT wait cycles, then EVAL and REPORT cycles.
            chk($sformatf("rec%0d timeout latency", i), n, TIMEOUT + 3);
        end else begin
            if (r.decoy) begin
                set_zone(r.zone, 77, 77);
                dht_ready = ~oh;
                tick();
                n++;
                dht_ready = '0;
            end
            set_zone(r.zone, r.temp, r.hum);
            while (n < r.delay - 1) begin
                tick();
                n++;
            end
            dht_ready = oh;
            tick();
            dht_ready = '0;
            tick();
            chk($sformatf("rec%0d fan latency", i), fan_on, r.fan);
            chk($sformatf("rec%0d rpt before actuator", i), rpt_if.rpt_valid, 0);
            tick();
        end
        chk($sformatf("rec%0d rpt_valid", i), rpt_if.rpt_valid, 1);
        chk($sformatf("rec%0d rpt_zone", i), rpt_if.rpt_zone, r.zone);
        chk($sformatf("rec%0d rpt_temp", i), rpt_if.rpt_temp, r.timeout ? 0 : r.temp);
        chk($sformatf("rec%0d rpt_hum", i), rpt_if.rpt_hum, r.timeout ? 0 : r.hum);
        chk($sformatf("rec%0d rpt_fault", i), rpt_if.rpt_fault, r.timeout);
        chk($sformatf("rec%0d fan_on", i), fan_on, r.fan);
        chk($sformatf("rec%0d hum_on", i), hum_on, r.hm);
        chk($sformatf("rec%0d sensor_fault", i), sensor_fault, r.flt);
        if (r.stall) begin
            bad = 0;
            for (int k = 0; k < 100; k++) begin
                tick();
                if (rpt_if.rpt_valid !== 1'b1 || rpt_if.rpt_zone !== ZW'(r.zone) ||
                    rpt_if.rpt_temp !== DW'(r.temp) || rpt_if.rpt_hum !== DW'(r.hum) ||
                    dht_en !== '0)
                    bad++;
            end
            chk($sformatf("rec%0d stall hold", i), bad, 0);
            rpt_if.rpt_ready = 1'b1;
        end
        tick();
        chk($sformatf("rec%0d rpt drop after handshake", i), rpt_if.rpt_valid, 0);
    endtask

    task automatic cfg_write(input int z, input int sel, input int val, input logic exp_err);
        cfg_wr   = 1'b1;
        cfg_zone = ZW'(z);
        cfg_sel  = 2'(sel);
        cfg_val  = DW'(val);
        tick();
        cfg_wr = 1'b0;
        chk($sformatf("cfg z%0d sel%0d=%0d err", z, sel, val), cfg_err, exp_err);
        tick();
        chk($sformatf("cfg z%0d sel%0d err pulse end", z, sel), cfg_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           zone dly  to    decoy stall temp hum  fan    hum    fault
        tbl[0]  = '{0, 5, 1'b0, 1'b0, 1'b0, 10, 80, 2'b01, 2'b01, 2'b00};
        tbl[1]  = '{1, 4, 1'b0, 1'b1, 1'b0,  5, 90, 2'b01, 2'b01, 2'b00};
        tbl[2]  = '{0, 7, 1'b0, 1'b0, 1'b0,  5, 90, 2'b01, 2'b01, 2'b00};
        tbl[3]  = '{1, 0, 1'b1, 1'b0, 1'b0,  0,  0, 2'b11, 2'b01, 2'b10};
        tbl[4]  = '{0, 3, 1'b0, 1'b0, 1'b0,  1, 99, 2'b10, 2'b00, 2'b10};
        tbl[5]  = '{1, 6, 1'b0, 1'b0, 1'b0,  5, 80, 2'b10, 2'b10, 2'b00};
        tbl[6]  = '{0, 5, 1'b0, 1'b1, 1'b0,  8, 95, 2'b10, 2'b10, 2'b00};
        tbl[7]  = '{1, 8, 1'b0, 1'b0, 1'b0,  2, 85, 2'b10, 2'b10, 2'b00};
        tbl[8]  = '{0, 5, 1'b0, 1'b0, 1'b0,  9, 84, 2'b11, 2'b11, 2'b00};
        tbl[9]  = '{1, 4, 1'b0, 1'b0, 1'b0,  1, 80, 2'b01, 2'b11, 2'b00};
        tbl[10] = '{0, 5, 1'b0, 1'b0, 1'b0,  8, 90, 2'b00, 2'b11, 2'b00};
        tbl[11] = '{1, 5, 1'b0, 1'b0, 1'b0,  9, 90, 2'b10, 2'b11, 2'b00};
        tbl[12] = '{0, 6, 1'b0, 1'b0, 1'b0, 11, 90, 2'b10, 2'b11, 2'b00};
        tbl[13] = '{1, 5, 1'b0, 1'b0, 1'b1,  5, 90, 2'b10, 2'b11, 2'b00};
        tbl[14] = '{0, 5, 1'b0, 1'b0, 1'b0, 13, 80, 2'b11, 2'b11, 2'b00};
        tbl[15] = '{0, 5, 1'b0, 1'b0, 1'b0,  9, 90, 2'b01, 2'b00, 2'b00};

        dht_ready = '0;
        temp_in   = '0;
        hum_in    = '0;
        cfg_wr    = 1'b0;
        cfg_zone  = '0;
        cfg_sel   = '0;
        cfg_val   = '0;
        rpt_if.rpt_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();
        chk_reset("reset state");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_rec(i);

        cfg_write(0, 1, 9, 1'b1);
        cfg_write(0, 0, 12, 1'b0);
        cfg_write(0, 1, 9, 1'b0);
        cfg_write(1, 2, 85, 1'b1);

        for (int i = 10; i < 15; i++) run_rec(i);

        wait_dht(2'b10, "pre-reset dht_en");
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk_reset("reset mid-wait");
        rst_n = 1'b1;
        run_rec(15);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/zone_climate_ctrl.md
Name: zone_climate_ctrl

Overview:
Parametrised successor to the single-sensor cold-storage control logic. Polls NUM_ZONES sensor readers round-robin and holds per-zone runtime-writable thresholds. Drives per-zone fan/humidifier actuators with hysteresis, flags sensor faults on timeout, and emits one report record per poll for the UART/LCD path.

Parameters:
NUM_ZONES, 4, zones/sensor readers (1..8)
DATA_W, 8, temperature/humidity width, unsigned
POLL_CYCLES, 2000000, idle clk cycles between zone polls
TIMEOUT_CYCLES, 5000000, max clk cycles from dht_en to data_ready
DEF_MAX_TEMP / DEF_MIN_TEMP, 8 / 2, reset temperature thresholds, all zones
DEF_MAX_HUM / DEF_MIN_HUM, 95 / 85, reset humidity thresholds, all zones
DWELL_CYCLES, 100000000, minimum actuator hold time (optional feature only)

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  reset, synchronous, active-low
dht_en  out  NUM_ZONES  one-hot read request, 1-cycle pulse
dht_data_ready  in  NUM_ZONES  per-zone reading-valid pulse
temp_in  in  NUM_ZONES*DATA_W  packed temperatures, zone z at [z*DATA_W +: DATA_W]
hum_in  in  NUM_ZONES*DATA_W  packed humidities, same packing
cfg_wr  in  1  threshold write strobe
cfg_zone  in  $clog2(NUM_ZONES)  target zone
cfg_sel  in  2  0=max_temp, 1=min_temp, 2=max_hum, 3=min_hum
cfg_val  in  DATA_W  threshold value
cfg_err  out  1  1-cycle pulse: write rejected
fan_on  out  NUM_ZONES  cooling fan per zone
hum_on  out  NUM_ZONES  humidifier per zone
sensor_fault  out  NUM_ZONES  sticky until next good read
rpt_valid  out  1  report record valid
rpt_ready  in  1  consumer accepts record
rpt_zone  out  $clog2(NUM_ZONES)  zone of record
rpt_temp / rpt_hum  out  DATA_W each  latched values (0 on fault)
rpt_fault  out  1  record is a timeout record

Behaviour:
- Reset (rst_n low at clk edge): state IDLE, zone index 0, counters 0. Thresholds reset to DEF_* values. All outputs 0.
- FSM: IDLE -> REQ -> WAIT -> EVAL -> REPORT -> IDLE.
- IDLE: counts POLL_CYCLES, then -> REQ.
- REQ: dht_en[z]=1 for exactly one cycle; timeout counter cleared; -> WAIT.
- WAIT: on dht_data_ready[z], latch temp/hum[z] -> EVAL (good). On TIMEOUT_CYCLES elapsed without ready -> EVAL (fault). Ready from other zones is ignored. A ready arriving after timeout is ignored.
- EVAL, good read: sensor_fault[z]<=0.
  - Fan: temp>max_temp -> 1; temp<min_temp -> 0; otherwise hold.
  - Humidifier: hum<min_hum -> 1; hum>max_hum -> 0; otherwise hold.
  - Comparisons are unsigned, strict.
- EVAL, fault: sensor_fault[z]<=1; fan_on[z]<=1 (fail-safe cooling); hum_on[z]<=0.
- EVAL uses threshold values as registered at that cycle. A same-cycle cfg_wr takes effect from the next cycle.
- REPORT: rpt_valid=1 with fields stable until rpt_valid&&rpt_ready. The transfer cycle advances z (wraps NUM_ZONES-1 -> 0) -> IDLE. Backpressure stalls the scheduler; the poll timer does not run. rpt_valid never drops without handshake.
- cfg_wr accepted in any state. Rejected with cfg_err pulse and no update if:
  - cfg_zone >= NUM_ZONES, or
  - the write would leave min >= max for that pair.
- Latency: dht_en to actuator update = ready arrival + 1 cycle. Actuator to rpt_valid = 1 cycle.
- rst_n low mid-poll: immediate return to reset state. Pending report is discarded.

Optional Feature:
CLIMATE_DWELL_EN. When defined: per-zone per-actuator dwell counters. A hysteresis-driven change to fan_on/hum_on is suppressed until DWELL_CYCLES have elapsed since that actuator's last change; the decision is re-evaluated on the next poll. Fault fail-safe overrides dwell. Counters start expired at reset. When undefined: no counters; changes apply immediately in EVAL.

Test Plan:
- NUM_ZONES=2, POLL_CYCLES=16, TIMEOUT_CYCLES=64. Zone0 ready 5 cycles after dht_en with temp=10, hum=80 -> fan_on[0]=1, hum_on[0]=1; report {0,10,80,0}.
- Zone0 temps 10,5,1 on successive polls -> fan_on[0] = 1,1,0 (hold at 5, off at 1).
- Zone1 never ready -> after 64 cycles sensor_fault[1]=1, fan_on[1]=1, hum_on[1]=0, rpt_fault=1, rpt_temp=0. Next good read clears fault.
- cfg_wr zone0 min_temp=9 while max_temp=8 -> cfg_err pulse, threshold unchanged. Write max_temp=12 then min_temp=9 -> accepted.
- rpt_ready held low 100 cycles -> rpt_valid and fields stable, no dht_en issued. Ready high -> zone index advances, poll resumes.
- Reset asserted during WAIT -> next cycle all outputs 0, thresholds at defaults, next poll targets zone0.
